// File: rtl/car_light_pkg.sv
// Shared encodings for the car light sequencer: switch modes and interior FSM states.
package car_light_pkg;

  // Interior main switch; 2'b11 behaves like OFF
  typedef enum logic [1:0] {
    INT_ON   = 2'b00,
    INT_DOOR = 2'b01,
    INT_OFF  = 2'b10
  } int_mode_e;

  // Exterior indicator control
  typedef enum logic [1:0] {
    EXT_OFF    = 2'b00,
    EXT_RIGHT  = 2'b01,
    EXT_LEFT   = 2'b10,
    EXT_HAZARD = 2'b11
  } ext_mode_e;

  // Interior light FSM states
  typedef enum logic [1:0] {
    ST_DARK = 2'b00,
    ST_LIT  = 2'b01,
    ST_HOLD = 2'b10
  } int_state_e;

endpackage

// File: rtl/indicator_sweep.sv
// Shared sweep generator: timer/step counters and a thermometer-coded segment pattern.
// The pattern reflects the current cycle's step (step 0 on a restart cycle) and is
// registered by the parent, giving one cycle of latency to the outputs.
module indicator_sweep #(
  parameter int unsigned SEG_COUNT  = 3,
  parameter int unsigned BLINK_HALF = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 run,
  output logic [SEG_COUNT-1:0] pattern
);

  localparam int unsigned TIMER_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned STEP_W  = $clog2(SEG_COUNT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BLINK_HALF - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SEG_COUNT);

  logic [TIMER_W-1:0] r_timer;
  logic [STEP_W-1:0]  r_step;
  logic [TIMER_W-1:0] w_timer_cur;
  logic [STEP_W-1:0]  w_step_cur;

  // Position used for this cycle plus its thermometer pattern
  always_comb begin
    w_timer_cur = (restart || !run) ? '0 : r_timer;
    w_step_cur  = (restart || !run) ? '0 : r_step;
    pattern     = '0;
    for (int i = 0; i < int'(SEG_COUNT); i++) begin
      pattern[i] = (STEP_W'(i) < w_step_cur);
    end
  end

  // Advance timer and step; hold both at zero while idle
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      r_timer <= '0;
      r_step  <= '0;
    end else if (w_timer_cur == TIMER_LAST) begin
      r_timer <= '0;
      r_step  <= (w_step_cur == STEP_LAST) ? '0 : w_step_cur + STEP_W'(1);
    end else begin
      r_timer <= w_timer_cur + TIMER_W'(1);
      r_step  <= w_step_cur;
    end
  end

endmodule

// File: rtl/car_light_sequencer.sv
// Car light sequencer: interior courtesy light FSM with door hold timer, and
// left/right/hazard indicator sweeps sharing one sweep generator.
module car_light_sequencer
  import car_light_pkg::*;
#(
  parameter int unsigned DOOR_COUNT  = 4,
  parameter int unsigned SEG_COUNT   = 3,
  parameter int unsigned BLINK_HALF  = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key,
  input  logic [DOOR_COUNT-1:0] door,
  input  logic [1:0]            int_mode,
  input  logic [1:0]            ext_mode,
  output logic                  light_int,
  output logic [SEG_COUNT-1:0]  left_seg,
  output logic [SEG_COUNT-1:0]  right_seg
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  int_state_e         r_state;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [1:0]         r_prev_ext;
  logic               r_prev_key;

  logic               w_occupied;
  logic               w_left_act;
  logic               w_right_act;
  logic               w_side_keyed;
  logic               w_restart;
  logic [SEG_COUNT-1:0] w_pattern;

  assign w_occupied   = (|door) | key;
  assign w_side_keyed = (ext_mode == EXT_LEFT) || (ext_mode == EXT_RIGHT);
  assign w_left_act   = ((ext_mode == EXT_LEFT) && key) || (ext_mode == EXT_HAZARD);
  assign w_right_act  = ((ext_mode == EXT_RIGHT) && key) || (ext_mode == EXT_HAZARD);
  assign w_restart    = (ext_mode != r_prev_ext) || (key && !r_prev_key && w_side_keyed);

  // Interior light FSM with hold counter; ON/OFF force DARK
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_DARK;
      r_hold_cnt <= '0;
      light_int  <= 1'b0;
    end else begin
      case (int_mode)
        INT_ON: begin
          r_state    <= ST_DARK;
          r_hold_cnt <= '0;
          light_int  <= 1'b1;
        end
        INT_DOOR: begin
          case (r_state)
            ST_DARK: begin
              if (w_occupied) begin
                r_state   <= ST_LIT;
                light_int <= 1'b1;
              end else begin
                light_int <= 1'b0;
              end
            end
            ST_LIT: begin
              if (!w_occupied) begin
                r_state    <= ST_HOLD;
                r_hold_cnt <= HOLD_LOAD;
              end
              light_int <= 1'b1;
            end
            ST_HOLD: begin
              if (w_occupied) begin
                r_state   <= ST_LIT;
                light_int <= 1'b1;
              end else if (r_hold_cnt == '0) begin
                r_state   <= ST_DARK;
                light_int <= 1'b0;
              end else begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                light_int  <= 1'b1;
              end
            end
            default: begin
              r_state   <= ST_DARK;
              light_int <= 1'b0;
            end
          endcase
        end
        default: begin
          r_state    <= ST_DARK;
          r_hold_cnt <= '0;
          light_int  <= 1'b0;
        end
      endcase
    end
  end

  indicator_sweep #(
    .SEG_COUNT  (SEG_COUNT),
    .BLINK_HALF (BLINK_HALF)
  ) u_sweep (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .run     (w_left_act | w_right_act),
    .pattern (w_pattern)
  );

  // Per-side gating of the shared pattern and restart-detection history
  always_ff @(posedge clk) begin
    if (rst) begin
      left_seg   <= '0;
      right_seg  <= '0;
      r_prev_ext <= 2'b00;
      r_prev_key <= 1'b0;
    end else begin
      left_seg   <= w_left_act  ? w_pattern : '0;
      right_seg  <= w_right_act ? w_pattern : '0;
      r_prev_ext <= ext_mode;
      r_prev_key <= key;
    end
  end

endmodule
